// File: rtl/scan_chain_host_if.sv
// Stream, control and scan-port signals of scan_chain_host.
// The crc output exists only when SCAN_CHAIN_HOST_CRC_EN is defined.
interface scan_chain_host_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       scan_enable;
  logic       scan_in;
  logic       scan_out;
`ifdef SCAN_CHAIN_HOST_CRC_EN
  logic [7:0] crc;
`endif

  // Controller / chain side.
  modport master (
    output start,
    input  busy,
    input  done,
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  scan_enable,
    input  scan_in,
`ifdef SCAN_CHAIN_HOST_CRC_EN
    input  crc,
`endif
    output scan_out
  );

  // scan_chain_host side.
  modport slave (
    input  start,
    output busy,
    output done,
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output scan_enable,
    output scan_in,
`ifdef SCAN_CHAIN_HOST_CRC_EN
    output crc,
`endif
    input  scan_out
  );
endinterface

// File: rtl/scan_chain_host.sv
// Host-side scan chain driver: one full chain rotation per start, bytes in/out on valid/ready.
// Define SCAN_CHAIN_HOST_CRC_EN to add a CRC-8 (poly 0x07) over the captured bit stream.
module scan_chain_host #(
  parameter int unsigned CHAIN_LEN  = 256,
  parameter int unsigned BYTE_CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  scan_chain_host_if.slave bus
);

  localparam int unsigned LastByte = CHAIN_LEN / 8 - 1;
  localparam logic [BYTE_CNT_W-1:0] LastByteCnt = BYTE_CNT_W'(LastByte);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StPush,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            tx_q, tx_d;
  logic [7:0]            rx_q, rx_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]            out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

`ifdef SCAN_CHAIN_HOST_CRC_EN
  logic [7:0] crc_q, crc_d;

  // One MSB-first CRC-8 step, polynomial x^8 + x^2 + x + 1.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef SCAN_CHAIN_HOST_CRC_EN
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef SCAN_CHAIN_HOST_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef SCAN_CHAIN_HOST_CRC_EN
    crc_d       = crc_q;
`endif

    // Consumer drain first; a PUSH in the same cycle re-sets out_valid below.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StLoad;
          byte_cnt_d = '0;
`ifdef SCAN_CHAIN_HOST_CRC_EN
          crc_d      = '0;
`endif
        end
      end

      StLoad: begin
        if (bus.in_valid) begin
          tx_d      = bus.in_data;
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end

      StShift: begin
        // scan_out is sampled pre-edge, i.e. the bit present during this cycle.
        tx_d      = {tx_q[6:0], 1'b0};
        rx_d      = {rx_q[6:0], bus.scan_out};
        bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef SCAN_CHAIN_HOST_CRC_EN
        crc_d     = crc8_step(crc_q, bus.scan_out);
`endif
        if (bit_cnt_q == 3'd7) begin
          state_d = StPush;
        end
      end

      StPush: begin
        if (!out_valid_q || bus.out_ready) begin
          out_data_d  = rx_q;
          out_valid_d = 1'b1;
          if (byte_cnt_q == LastByteCnt) begin
            state_d = StDone;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = StLoad;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // All outputs decode from registers; reset clears scan_enable asynchronously via state_q.
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.in_ready    = (state_q == StLoad);
  assign bus.scan_enable = (state_q == StShift);
  assign bus.scan_in     = (state_q == StShift) & tx_q[7];
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
`ifdef SCAN_CHAIN_HOST_CRC_EN
  assign bus.crc         = crc_q;
`endif

endmodule
